lut_neuron_table_loader: RTL and testbench
==========================================

Name: lut_neuron_table_loader

Overview:
- Run-time programmable counterpart of the fixed truth-table neurons: a configuration writer streams a neuron truth table into distributed RAM, and the inference path reads it back.
- Lets one netlist serve retrained quantised neurons of the HGCal autoencoder without resynthesis.
- Sits between the configuration bus (writer end) and the layer datapath (reader end).
- Inference lookup is registered, with latency 1.

Parameters:
IN_BITS, 8, lookup address width (concatenated quantised neuron inputs)
OUT_BITS, 2, width of each table entry (quantised neuron output)
DEPTH, 2**IN_BITS, number of table entries; the RTL derives it and it is not overridable

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
cfg_start  in  1  pulse: begin a (re)load from address 0
cfg_valid  in  1  table entry beat valid
cfg_ready  out  1  loader accepts a beat this cycle
cfg_data  in  OUT_BITS  entry value for current load address
cfg_busy  out  1  high while in LOAD
table_ok  out  1  high while in READY (complete table held)
lut_valid_in  in  1  lookup request valid
lut_in  in  IN_BITS  lookup address (neuron input word)
lut_valid_out  out  1  lookup result valid
lut_out  out  OUT_BITS  lookup result

Behaviour:
- Clocking and reset: one clock domain, synchronous active-high reset.
- Reset values: state=EMPTY, load address=0, cfg_ready=0, cfg_busy=0, table_ok=0, lut_valid_out=0, lut_out=0.
- RAM contents are not cleared by reset. They are unusable until a complete load finishes.
- States:
  - EMPTY → LOAD on cfg_start.
  - LOAD → READY when the beat at address DEPTH-1 is accepted.
  - READY → LOAD on cfg_start.
  - LOAD + cfg_start → LOAD with address reset to 0. This takes priority over a same-cycle beat; that beat is dropped and not written.
- cfg_ready = (state==LOAD) combinationally. A beat is accepted when cfg_valid && cfg_ready.
- Each accepted beat writes RAM[addr] = cfg_data, then addr increments.
  - Entry order is strictly ascending: entry k is the output for lut_in == k.
  - addr is IN_BITS wide; it never wraps within a load because the final beat exits LOAD.
- cfg_busy = (state==LOAD). table_ok = (state==READY). Both are registered state decodes.
- Lookup timing:
  - Sampled on any cycle lut_valid_in=1.
  - Next cycle: lut_valid_out=1, and lut_out = RAM[lut_in] if the state was READY in the request cycle, else 0.
  - lut_valid_out=0 on any cycle following lut_valid_in=0; lut_out holds its last value then.
- Lookups never stall and have no backpressure; throughput is one per cycle.
- Boundary behaviour:
  - Lookup in the same cycle as the final accepted beat: state is still LOAD, so the result is 0. The first valid table lookup is one cycle later.
  - Lookup in the same cycle as cfg_start while READY: served from the old table (state still READY). The next cycle returns 0.
  - Reset mid-load: back to EMPTY, partial table discarded logically. A lookup in the reset cycle yields lut_valid_out=0 next cycle.
  - cfg_valid outside LOAD is ignored; no write occurs.
- RAM: DEPTH×OUT_BITS, synchronous write, asynchronous read feeding the output register. Mark it distributed ROM/RAM style for LUTRAM inference.

Test Plan:
- Reset then lookups of 0x00 and 0xFF → lut_valid_out=1 one cycle after each request, lut_out=2'b00, table_ok=0.
- Load 256 beats with entry[k]=k[1:0], cfg_valid held high → cfg_ready high for exactly 256 cycles; table_ok rises the cycle after the 256th beat; lookup 0x87 → 2'b11, lookup 0x84 → 2'b00.
- Load with random cfg_valid gaps, entry[0x84]=2'b01, entry[0x48]=2'b01, others 0 → lookups 0x84→01, 0x48→01, 0x85→00; back-to-back lookups every cycle return in order.
- Complete a load, then pulse cfg_start with a lookup of 0x84 in the same cycle → that lookup returns the old value; a lookup one cycle later returns 00; table_ok=0 until the new load completes.
- Mid-load (after 100 beats) assert cfg_start together with cfg_valid → beat dropped, address restarts at 0; 256 further beats are needed before table_ok=1, and the loaded data matches the second stream.
- Assert rst at beat 200 → cfg_busy=0 and table_ok=0 the next cycle; lookups return 00 until a full reload completes.

Source files
------------

// File: rtl/lut_neuron_table_loader.sv
// Run-time loadable truth-table neuron.
// A configuration writer streams DEPTH entries (ascending address order) into
// a distributed RAM; the inference path looks entries up with one cycle of
// latency. Lookups return 0 unless a complete table is held.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   EMPTY   | no usable table since reset; lookups return 0
//   LOAD    | accepting table beats at addr; lookups return 0
//   READY   | complete table held; lookups return RAM[lut_in]

module lut_neuron_table_loader #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [OUT_BITS-1:0] cfg_data,
   output logic                cfg_busy,
   output logic                table_ok,
   input  logic                lut_valid_in,
   input  logic [IN_BITS-1:0]  lut_in,
   output logic                lut_valid_out,
   output logic [OUT_BITS-1:0] lut_out
);

   localparam int DEPTH = 2 ** IN_BITS;

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;

   logic [1:0]          state;
   logic [IN_BITS-1:0]  addr;
   logic                beat_wr;
   logic [OUT_BITS-1:0] rd_data;

   (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [DEPTH];

   assign cfg_ready = (state == S_LOAD);
   assign cfg_busy  = (state == S_LOAD);
   assign table_ok  = (state == S_READY);

   // A restart in LOAD wins over a same-cycle beat, so that beat is never written.
   assign beat_wr = cfg_valid && cfg_ready && !cfg_start;

   assign rd_data = mem[lut_in];

   // Load sequencing: state and write address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_EMPTY;
         addr  <= '0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (cfg_start) begin
                  state <= S_LOAD;
                  addr  <= '0;
               end
            end
            S_LOAD: begin
               if (cfg_start) begin
                  addr <= '0;
               end else if (beat_wr) begin
                  addr <= addr + 1'b1;
                  if (addr == {IN_BITS{1'b1}}) begin
                     state <= S_READY;
                  end
               end
            end
            S_READY: begin
               if (cfg_start) begin
                  state <= S_LOAD;
                  addr  <= '0;
               end
            end
            default: begin
               state <= S_EMPTY;
               addr  <= '0;
            end
         endcase
      end
   end

   // Table RAM write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (beat_wr) begin
         mem[addr] <= cfg_data;
      end
   end

   // Registered lookup; result is forced to 0 unless the table was complete.
   always_ff @(posedge clk) begin
      if (rst) begin
         lut_valid_out <= 1'b0;
         lut_out       <= '0;
      end else begin
         lut_valid_out <= lut_valid_in;
         if (lut_valid_in) begin
            lut_out <= (state == S_READY) ? rd_data : '0;
         end
      end
   end

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Directed bench for lut_neuron_table_loader: reset, loads with and without
// gaps, restart/reset boundary cases, back-to-back lookups.

module tb_lut_neuron_table_loader;

   logic       clk;
   logic       rst;
   logic       cfg_start;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_data;
   logic       cfg_busy;
   logic       table_ok;
   logic       lut_valid_in;
   logic [7:0] lut_in;
   logic       lut_valid_out;
   logic [1:0] lut_out;

   int n_vec = 0;
   int n_err = 0;

   lut_neuron_table_loader #(.IN_BITS(8), .OUT_BITS(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_data      (cfg_data),
      .cfg_busy      (cfg_busy),
      .table_ok      (table_ok),
      .lut_valid_in  (lut_valid_in),
      .lut_in        (lut_in),
      .lut_valid_out (lut_valid_out),
      .lut_out       (lut_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // table patterns used by the loads
   function automatic logic [1:0] entry(input int pat, input int k);
      logic [7:0] kk;
      kk = k[7:0];
      case (pat)
         0: entry = kk[1:0];
         1: entry = (kk == 8'h84 || kk == 8'h48) ? 2'b01 : 2'b00;
         2: entry = kk[3:2];
         default: entry = {kk[0], kk[7]};
      endcase
   endfunction

   // n beats of pattern pat starting at entry first; optional idle gaps
   task automatic beats(input int pat, input int first, input int n, input bit gaps);
      for (int k = first; k < first + n; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            cfg_valid = 1'b0;
            cfg_data  = 2'b11;
            step();
         end
         cfg_valid = 1'b1;
         cfg_data  = entry(pat, k);
         step();
      end
      cfg_valid = 1'b0;
   endtask

   task automatic start_pulse();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [7:0] a, input logic [1:0] exp);
      lut_valid_in = 1'b1;
      lut_in       = a;
      step();
      lut_valid_in = 1'b0;
      check({tag, "_vld"}, lut_valid_out, 1'b1);
      check(tag, lut_out, exp);
   endtask

   int ready_cnt;
   logic [7:0] seq_a [4];
   logic [1:0] seq_e [4];

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 2'b00;
      lut_valid_in = 1'b0; lut_in = 8'h00;
      step();
      step();
      rst = 1'b0;

      // reset state
      check("rst_ready", cfg_ready, 1'b0);
      check("rst_busy", cfg_busy, 1'b0);
      check("rst_ok", table_ok, 1'b0);
      check("rst_vout", lut_valid_out, 1'b0);
      check("rst_out", lut_out, 2'b00);
      lookup("empty_00", 8'h00, 2'b00);
      lookup("empty_ff", 8'hFF, 2'b00);
      check("empty_ok", table_ok, 1'b0);
      step();
      check("idle_vout", lut_valid_out, 1'b0);

      // cfg_valid while EMPTY is ignored
      cfg_valid = 1'b1;
      check("empty_no_ready", cfg_ready, 1'b0);
      step();
      cfg_valid = 1'b0;

      // full load, valid held high, entry[k] = k[1:0]
      start_pulse();
      ready_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         cfg_valid = 1'b1;
         cfg_data  = entry(0, k);
         if (cfg_ready) ready_cnt++;
         if (k == 255) begin
            check("last_beat_ok", table_ok, 1'b0);
            lut_valid_in = 1'b1;
            lut_in       = 8'h87;
         end
         step();
      end
      cfg_valid    = 1'b0;
      lut_valid_in = 1'b0;
      check("same_cycle_final_lookup", lut_out, 2'b00);
      check("ready_count", ready_cnt, 256);
      check("ready_drop", cfg_ready, 1'b0);
      check("load1_ok", table_ok, 1'b1);
      check("load1_busy", cfg_busy, 1'b0);
      lookup("l1_87", 8'h87, 2'b11);
      lookup("l1_84", 8'h84, 2'b00);
      lookup("l1_02", 8'h02, 2'b10);

      // gapped load, only 0x84 and 0x48 set to 01
      start_pulse();
      check("load2_busy", cfg_busy, 1'b1);
      beats(1, 0, 256, 1'b1);
      check("load2_ok", table_ok, 1'b1);
      lookup("l2_84", 8'h84, 2'b01);
      lookup("l2_48", 8'h48, 2'b01);
      lookup("l2_85", 8'h85, 2'b00);

      // back-to-back lookups, one per cycle
      seq_a[0] = 8'h84; seq_e[0] = 2'b01;
      seq_a[1] = 8'h85; seq_e[1] = 2'b00;
      seq_a[2] = 8'h48; seq_e[2] = 2'b01;
      seq_a[3] = 8'h49; seq_e[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         lut_valid_in = 1'b1;
         lut_in       = seq_a[i];
         step();
         check("b2b_vld", lut_valid_out, 1'b1);
         check("b2b_out", lut_out, seq_e[i]);
      end
      lut_valid_in = 1'b0;

      // restart from READY with a lookup in the same cycle: old table answers
      cfg_start    = 1'b1;
      lut_valid_in = 1'b1;
      lut_in       = 8'h84;
      step();
      cfg_start = 1'b0;
      check("restart_old", lut_out, 2'b01);
      check("restart_busy", cfg_busy, 1'b1);
      check("restart_ok", table_ok, 1'b0);
      step();
      lut_valid_in = 1'b0;
      check("restart_next", lut_out, 2'b00);
      beats(2, 0, 255, 1'b0);
      check("load3_pre_ok", table_ok, 1'b0);
      beats(2, 255, 1, 1'b0);
      check("load3_ok", table_ok, 1'b1);
      lookup("l3_84", 8'h84, 2'b01);
      lookup("l3_8c", 8'h8C, 2'b11);

      // restart mid-load with a same-cycle beat: beat dropped, address back to 0
      start_pulse();
      beats(0, 0, 100, 1'b0);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 2'b11;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      check("mid_busy", cfg_busy, 1'b1);
      beats(3, 0, 255, 1'b1);
      check("mid_pre_ok", table_ok, 1'b0);
      check("mid_pre_busy", cfg_busy, 1'b1);
      beats(3, 255, 1, 1'b0);
      check("mid_ok", table_ok, 1'b1);
      lookup("l4_00", 8'h00, 2'b00);
      lookup("l4_01", 8'h01, 2'b10);
      lookup("l4_80", 8'h80, 2'b01);
      lookup("l4_81", 8'h81, 2'b11);
      lookup("l4_63", 8'h63, 2'b10);
      lookup("l4_64", 8'h64, 2'b00);

      // reset at beat 200 with a lookup in the reset cycle
      start_pulse();
      beats(0, 0, 200, 1'b0);
      rst          = 1'b1;
      lut_valid_in = 1'b1;
      lut_in       = 8'h87;
      step();
      rst          = 1'b0;
      lut_valid_in = 1'b0;
      check("rstmid_busy", cfg_busy, 1'b0);
      check("rstmid_ok", table_ok, 1'b0);
      check("rstmid_vout", lut_valid_out, 1'b0);
      lookup("rstmid_87", 8'h87, 2'b00);
      start_pulse();
      beats(0, 0, 200, 1'b0);
      lookup("reload_part_87", 8'h87, 2'b00);
      start_pulse();
      beats(0, 0, 256, 1'b0);
      check("reload_ok", table_ok, 1'b1);
      lookup("reload_87", 8'h87, 2'b11);
      lookup("reload_fe", 8'hFE, 2'b10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
